// File: rtl/ahb_pkg.sv
// Shared AHB encodings and the SRAM responder state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StData,
    StErr1,
    StErr2
  } sram_state_e;

  // Little-endian lane enables for a legal transfer size.
  function automatic logic [3:0] ahb_byte_en(logic [2:0] size, logic [1:0] lane);
    case (size)
      HSIZE_BYTE: return 4'b0001 << lane;
      HSIZE_HALF: return lane[1] ? 4'b1100 : 4'b0011;
      default:    return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// AHB bus signals seen by one slave port; HREADY is driven by the interconnect.
interface ahb_sram_slave_if;

  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic [1:0]  HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );

endinterface

// File: rtl/ahb_sram_mem.sv
// Word-wide SRAM array with per-byte write enables and asynchronous read; no reset.
module ahb_sram_mem #(
  parameter int unsigned Depth = 256,
  parameter int unsigned IdxW  = 8
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [3:0]      be_i,
  input  logic [IdxW-1:0] addr_i,
  input  logic [31:0]     wdata_i,
  output logic [31:0]     rdata_o
);

  logic [31:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB SRAM responder: byte/half/word access, programmable wait states, two-cycle ERROR.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned ADDR_BITS   = 16,
  parameter int unsigned WAIT_STATES = 0
) (
  input logic             HCLK,
  input logic             HRESETn,
  ahb_sram_slave_if.slave bus
);

  localparam int unsigned IdxW     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [31:0] ByteSpan = 32'(4 * MEM_DEPTH);
  localparam logic [3:0]  WaitLoad = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  sram_state_e          state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 write_q, write_d;
  logic [2:0]           size_q, size_d;
  logic [3:0]           wait_cnt_q, wait_cnt_d;

  logic                 accept;
  logic                 legal;
  logic                 can_start;
  logic [ADDR_BITS-1:0] offset;
  logic [IdxW-1:0]      mem_idx;
  logic [3:0]           mem_be;
  logic                 mem_we;
  logic [31:0]          mem_rdata;
  logic                 unused_bits;

  assign offset    = bus.HADDR[ADDR_BITS-1:0];
  assign accept    = bus.HSEL & bus.HREADY & bus.HTRANS[1];
  // States where this slave's HREADYOUT is high, so a new address phase can land.
  assign can_start = (state_q == StIdle) || (state_q == StData) || (state_q == StErr2);

  always_comb begin
    legal = 1'b1;
    if (bus.HSIZE > HSIZE_WORD) begin
      legal = 1'b0;
    end
    if ((bus.HSIZE == HSIZE_HALF) && bus.HADDR[0]) begin
      legal = 1'b0;
    end
    if ((bus.HSIZE == HSIZE_WORD) && (bus.HADDR[1:0] != 2'b00)) begin
      legal = 1'b0;
    end
    if (32'(offset) >= ByteSpan) begin
      legal = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    write_d    = write_q;
    size_d     = size_q;
    wait_cnt_d = wait_cnt_q;

    unique case (state_q)
      StWait: begin
        if (wait_cnt_q == 4'd0) begin
          state_d = StData;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      StErr1: state_d = StErr2;
      StIdle, StData, StErr2: begin
        state_d = StIdle;
        if (can_start && accept) begin
          addr_d  = offset;
          write_d = bus.HWRITE;
          size_d  = bus.HSIZE;
          if (!legal) begin
            state_d = StErr1;
          end else if (WAIT_STATES > 0) begin
            state_d    = StWait;
            wait_cnt_d = WaitLoad;
          end else begin
            state_d = StData;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      write_q    <= 1'b0;
      size_q     <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      size_q     <= size_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign mem_idx = IdxW'(addr_q >> 2);
  assign mem_be  = ahb_byte_en(size_q, addr_q[1:0]);
  assign mem_we  = (state_q == StData) && write_q;

  ahb_sram_mem #(
    .Depth (MEM_DEPTH),
    .IdxW  (IdxW)
  ) u_mem (
    .clk_i   (HCLK),
    .we_i    (mem_we),
    .be_i    (mem_be),
    .addr_i  (mem_idx),
    .wdata_i (bus.HWDATA),
    .rdata_o (mem_rdata)
  );

  assign bus.HREADYOUT = !((state_q == StWait) || (state_q == StErr1));
  assign bus.HRESP     = ((state_q == StErr1) || (state_q == StErr2)) ? HRESP_ERROR : HRESP_OKAY;
  assign bus.HRDATA    = ((state_q == StData) && !write_q) ? mem_rdata : 32'h0;

  // Burst type and address bits above the window do not affect the access.
  assign unused_bits = ^{bus.HBURST, bus.HADDR};

  a_resp_legal : assert property (@(posedge HCLK) disable iff (!HRESETn)
    bus.HRESP[1] == 1'b0);
  a_err_pair : assert property (@(posedge HCLK) disable iff (!HRESETn)
    (state_q == StErr1) |=> (state_q == StErr2));

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboarded bench: two slaves (0 and 3 wait states) behind a small bus mux.
module tb_ahb_sram_slave;
  import ahb_pkg::*;

  typedef struct {
    bit          dut;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          waits;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n0, rst_n1;
  logic        hsel0, hsel1, hwrite, force_nready, hready;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic        dsel0_q = 1'b0;
  logic        dsel1_q = 1'b0;
  int          cyc = 0;
  int          acc_cyc, done_cyc;
  int          n_cmp = 0;
  int          n_fail = 0;
  exp_t        sb[$];

  always #5 clk = ~clk;

  ahb_sram_slave_if bus0();
  ahb_sram_slave_if bus1();

  assign bus0.HSEL = hsel0;  assign bus1.HSEL = hsel1;
  assign bus0.HADDR = haddr; assign bus1.HADDR = haddr;
  assign bus0.HTRANS = htrans; assign bus1.HTRANS = htrans;
  assign bus0.HWRITE = hwrite; assign bus1.HWRITE = hwrite;
  assign bus0.HSIZE = hsize; assign bus1.HSIZE = hsize;
  assign bus0.HBURST = hburst; assign bus1.HBURST = hburst;
  assign bus0.HWDATA = hwdata; assign bus1.HWDATA = hwdata;
  assign bus0.HREADY = hready; assign bus1.HREADY = hready;

  // Interconnect ready: follows the slave owning the data phase, default slave otherwise.
  assign hready = force_nready ? 1'b0 :
                  dsel0_q ? bus0.HREADYOUT : dsel1_q ? bus1.HREADYOUT : 1'b1;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (hready) begin
      dsel0_q <= hsel0;
      dsel1_q <= hsel1;
    end
  end

  ahb_sram_slave #(.MEM_DEPTH(256), .ADDR_BITS(16), .WAIT_STATES(0)) u_dut0 (
    .HCLK(clk), .HRESETn(rst_n0), .bus(bus0)
  );
  ahb_sram_slave #(.MEM_DEPTH(256), .ADDR_BITS(16), .WAIT_STATES(3)) u_dut1 (
    .HCLK(clk), .HRESETn(rst_n1), .bus(bus1)
  );

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
    end
  endfunction

  // Monitor: counts stall cycles of the head entry, then compares on its ready cycle.
  initial begin
    int          w;
    exp_t        e;
    logic        ro;
    logic [1:0]  rs;
    logic [31:0] rd;
    w = 0;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e  = sb[0];
        ro = e.dut ? bus1.HREADYOUT : bus0.HREADYOUT;
        rs = e.dut ? bus1.HRESP : bus0.HRESP;
        rd = e.dut ? bus1.HRDATA : bus0.HRDATA;
        if (!ro) begin
          w++;
          check({e.name, "_stall_resp"}, 32'(rs), 32'(e.resp));
        end else begin
          void'(sb.pop_front());
          check({e.name, "_waits"}, 32'(w), 32'(e.waits));
          check({e.name, "_resp"}, 32'(rs), 32'(e.resp));
          check({e.name, "_rdata"}, rd, e.rdata);
          w = 0;
          done_cyc = cyc + 1;
        end
      end
    end
  end

  task automatic wait_accept(output bit ok);
    logic r;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      r = hready;
      @(posedge clk);
      #1;
      if (r) begin
        ok = 1'b1;
        return;
      end
    end
    n_cmp++;
    n_fail++;
    $display("FAIL accept_timeout: HREADY stayed 0 for 64 cycles, required 1");
  endtask

  task automatic issue(input bit d, input bit sel, input logic [31:0] a, input logic [1:0] tr,
                       input bit w, input logic [2:0] sz, input logic [31:0] wd,
                       input logic [31:0] erd, input logic [1:0] ersp, input int ew,
                       input string nm);
    exp_t e;
    bit   ok;
    hsel0 = sel & !d; hsel1 = sel & d;
    haddr = a; htrans = tr; hwrite = w; hsize = sz;
    wait_accept(ok);
    hwdata  = wd;
    acc_cyc = cyc;
    e.dut = d; e.rdata = erd; e.resp = ersp; e.waits = ew; e.name = nm;
    sb.push_back(e);
    hsel0 = 1'b0; hsel1 = 1'b0; htrans = HTRANS_IDLE;
  endtask

  task automatic wr(input bit d, input logic [31:0] a, input logic [2:0] sz,
                    input logic [31:0] wd, input string nm);
    issue(d, 1'b1, a, HTRANS_NONSEQ, 1'b1, sz, wd, 32'h0, HRESP_OKAY, d ? 3 : 0, nm);
  endtask

  task automatic rd(input bit d, input logic [31:0] a, input logic [1:0] tr,
                    input logic [31:0] exp, input string nm);
    issue(d, 1'b1, a, tr, 1'b0, HSIZE_WORD, 32'h0, exp, HRESP_OKAY, d ? 3 : 0, nm);
  endtask

  task automatic bad(input bit d, input logic [31:0] a, input bit w, input logic [2:0] sz,
                     input string nm);
    issue(d, 1'b1, a, HTRANS_NONSEQ, w, sz, 32'hFFFF_FFFF, 32'h0, HRESP_ERROR, 1, nm);
  endtask

  task automatic drain();
    bit ok;
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      hsel0 = 1'b0; hsel1 = 1'b0; htrans = HTRANS_IDLE;
      wait_accept(ok);
      if (!ok) break;
    end
    hsel0 = 1'b0; hsel1 = 1'b0; htrans = HTRANS_IDLE;
    wait_accept(ok);
    if (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d responses outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    bit ok;
    int t0;
    rst_n0 = 1'b0; rst_n1 = 1'b0; force_nready = 1'b0;
    hsel0 = 1'b0; hsel1 = 1'b0; haddr = '0; htrans = HTRANS_IDLE; hwrite = 1'b0;
    hsize = HSIZE_WORD; hburst = HBURST_SINGLE; hwdata = '0;
    repeat (3) @(negedge clk);
    check("rst0_ready", 32'(bus0.HREADYOUT), 32'd1);
    check("rst0_resp", 32'(bus0.HRESP), 32'd0);
    check("rst0_rdata", bus0.HRDATA, 32'h0);
    check("rst1_ready", 32'(bus1.HREADYOUT), 32'd1);
    check("rst1_resp", 32'(bus1.HRESP), 32'd0);
    check("rst1_rdata", bus1.HRDATA, 32'h0);
    rst_n0 = 1'b1; rst_n1 = 1'b1;
    @(posedge clk); #1;

    // Zero-wait slave: write-then-read forwarding, lanes, errors, boundaries.
    wr(0, 32'h10, HSIZE_WORD, 32'hDEAD_BEEF, "t1_wr10");
    rd(0, 32'h10, HTRANS_NONSEQ, 32'hDEAD_BEEF, "t1_rd10");
    rd(0, 32'h0001_0010, HTRANS_NONSEQ, 32'hDEAD_BEEF, "t1_rd_upper_ignored");
    wr(0, 32'h20, HSIZE_WORD, 32'h0, "t2_wr20");
    wr(0, 32'h21, HSIZE_BYTE, 32'hCCCC_AACC, "t2_wb21");
    wr(0, 32'h23, HSIZE_BYTE, 32'h55CC_CCCC, "t2_wb23");
    rd(0, 32'h20, HTRANS_NONSEQ, 32'h5500_AA00, "t2_rd20a");
    wr(0, 32'h22, HSIZE_HALF, 32'h1234_CCCC, "t2_wh22");
    rd(0, 32'h20, HTRANS_NONSEQ, 32'h1234_AA00, "t2_rd20b");
    wr(0, 32'h30, HSIZE_WORD, 32'hCAFE_F00D, "t3_wr30");
    bad(0, 32'h31, 1'b1, HSIZE_HALF, "t3_err_half31");
    bad(0, 32'h402, 1'b0, HSIZE_WORD, "t3_err_rd402");
    bad(0, 32'h400, 1'b0, HSIZE_WORD, "t3_err_rd400");
    bad(0, 32'h30, 1'b1, 3'b011, "t3_err_size3");
    rd(0, 32'h30, HTRANS_NONSEQ, 32'hCAFE_F00D, "t3_rd30");
    wr(0, 32'h3FC, HSIZE_WORD, 32'h0BAD_F00D, "t3_wr3fc");
    rd(0, 32'h3FC, HTRANS_NONSEQ, 32'h0BAD_F00D, "t3_rd3fc");
    issue(0, 1'b1, 32'h10, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0, 32'h0, HRESP_OKAY, 0,
          "t5_idle0");
    drain();

    // Three-wait slave: preload, then INCR4 timing.
    wr(1, 32'h40, HSIZE_WORD, 32'hA0A0_0040, "t4_wr40");
    wr(1, 32'h44, HSIZE_WORD, 32'hA0A0_0044, "t4_wr44");
    wr(1, 32'h48, HSIZE_WORD, 32'hA0A0_0048, "t4_wr48");
    wr(1, 32'h4C, HSIZE_WORD, 32'hA0A0_004C, "t4_wr4c");
    wr(1, 32'h50, HSIZE_WORD, 32'h5050_5050, "t4_wr50");
    drain();
    hburst = HBURST_INCR4;
    rd(1, 32'h40, HTRANS_NONSEQ, 32'hA0A0_0040, "t4_b0");
    t0 = acc_cyc;
    rd(1, 32'h44, HTRANS_SEQ, 32'hA0A0_0044, "t4_b1");
    rd(1, 32'h48, HTRANS_SEQ, 32'hA0A0_0048, "t4_b2");
    rd(1, 32'h4C, HTRANS_SEQ, 32'hA0A0_004C, "t4_b3");
    drain();
    check("t4_total_cycles", 32'(done_cyc - t0), 32'd16);

    // No-access stimulus: IDLE, deselected, and stalled by another slave.
    hburst = HBURST_SINGLE;
    issue(1, 1'b1, 32'h40, HTRANS_IDLE, 1'b1, HSIZE_WORD, 32'hBAD0_0040, 32'h0, HRESP_OKAY, 0,
          "t5_idle1");
    issue(1, 1'b0, 32'h44, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'hBAD0_0044, 32'h0, HRESP_OKAY,
          0, "t5_nosel");
    drain();
    force_nready = 1'b1;
    hsel1 = 1'b1; haddr = 32'h48; htrans = HTRANS_NONSEQ; hwrite = 1'b1; hsize = HSIZE_WORD;
    hwdata = 32'hBAD0_0048;
    @(posedge clk); #1;
    hsel1 = 1'b0; htrans = HTRANS_IDLE;
    @(negedge clk);
    check("t5_nready_ready", 32'(bus1.HREADYOUT), 32'd1);
    check("t5_nready_resp", 32'(bus1.HRESP), 32'd0);
    force_nready = 1'b0;
    @(posedge clk); #1;

    // INCR4 with BUSY between beats 2 and 3; also shows the no-access writes had no effect.
    hburst = HBURST_INCR4;
    rd(1, 32'h40, HTRANS_NONSEQ, 32'hA0A0_0040, "t5_b0");
    rd(1, 32'h44, HTRANS_SEQ, 32'hA0A0_0044, "t5_b1");
    issue(1, 1'b1, 32'h48, HTRANS_BUSY, 1'b0, HSIZE_WORD, 32'h0, 32'h0, HRESP_OKAY, 0,
          "t5_busy");
    rd(1, 32'h48, HTRANS_SEQ, 32'hA0A0_0048, "t5_b2");
    rd(1, 32'h4C, HTRANS_SEQ, 32'hA0A0_004C, "t5_b3");
    drain();

    // Reset during the wait states of a write drops the write.
    hburst = HBURST_SINGLE;
    hsel1 = 1'b1; haddr = 32'h50; htrans = HTRANS_NONSEQ; hwrite = 1'b1; hsize = HSIZE_WORD;
    wait_accept(ok);
    hwdata = 32'hDEAD_0050;
    hsel1 = 1'b0; htrans = HTRANS_IDLE;
    @(posedge clk); #1;
    check("t6_pre_ready", 32'(bus1.HREADYOUT), 32'd0);
    rst_n1 = 1'b0;
    #1;
    check("t6_rst_ready", 32'(bus1.HREADYOUT), 32'd1);
    check("t6_rst_resp", 32'(bus1.HRESP), 32'd0);
    check("t6_rst_rdata", bus1.HRDATA, 32'h0);
    repeat (2) @(negedge clk);
    rst_n1 = 1'b1;
    @(posedge clk); #1;
    rd(1, 32'h50, HTRANS_NONSEQ, 32'h5050_5050, "t6_rd50");
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
